// File: rtl/imem_fetch_sequencer.sv
// Purpose : sequences reads of the 64-word instruction memory, keeps the PC and hands one
//           instruction per cycle to decode; absorbs EX redirects and stops at the END sentinel.
// Latency : start -> first if_valid after 2 edges; redirect -> target word after 2 edges (1 bubble).
// Backpressure: valid/ready to decode; with if_ready=0 the presented word and the pc hold.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start, start_pc          begin fetching at start_pc (only from IDLE or HALT)
//   imem_addr, imem_rdata    memory read address (= pc) and combinational read data
//   redirect, redirect_pc    taken branch/jump resolved in EX, absolute word target
//   if_valid/if_ready        handshake to decode; if_instr, if_pc, if_last carry the word
//   busy, halted             state is RUN / state is HALT with nothing presented
//   issued_cnt               completed handshakes, saturating, cleared on start
//
// Build option: define FETCH_JUMP_PREDECODE_EN to follow 'j' targets at fetch time
// (no bubble). EX must then not redirect for 'j'.

module imem_fetch_sequencer #(
  parameter int          DEPTH    = 64,
  parameter int          AW       = 6,
  parameter logic [31:0] END_WORD = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_pc,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [31:0]   if_instr,
  output logic [AW-1:0] if_pc,
  output logic          if_last,
  output logic          busy,
  output logic          halted,
  output logic [15:0]   issued_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          if_valid_q, if_valid_d;
  logic [31:0]   if_instr_q, if_instr_d;
  logic [AW-1:0] if_pc_q, if_pc_d;
  logic          if_last_q, if_last_d;
  logic [15:0]   issued_cnt_q, issued_cnt_d;

  logic          handshake;
  logic          redirect_take;
  logic          start_take;
  logic          load;
  logic          is_end;
  logic [AW-1:0] pc_inc;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    if_last_d    = if_last_q;
    issued_cnt_d = issued_cnt_q;

    handshake     = if_valid_q && if_ready;
    // Redirects only mean something once a program is running; a redirect in
    // HALT also beats a simultaneous start.
    redirect_take = redirect && (state_q != S_IDLE);
    start_take    = start && (state_q != S_RUN) && !redirect_take;
    load          = (state_q == S_RUN) && (!if_valid_q || if_ready) && !redirect;
    is_end        = (imem_rdata == END_WORD);
    pc_inc        = (pc_q == AW'(DEPTH - 1)) ? '0 : pc_q + 1'b1;

    // The outgoing word counts even when a redirect flushes the output stage.
    if (handshake && (issued_cnt_q != 16'hFFFF)) begin
      issued_cnt_d = issued_cnt_q + 16'd1;
    end

    if (redirect_take) begin
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      if_last_d  = 1'b0;
      state_d    = S_RUN;
    end else if (start_take) begin
      pc_d         = start_pc;
      if_valid_d   = 1'b0;
      if_last_d    = 1'b0;
      issued_cnt_d = '0;
      state_d      = S_RUN;
    end else if (load) begin
      if_instr_d = imem_rdata;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      if_last_d  = is_end;
      if (is_end) begin
        // pc stays on the sentinel; HALT keeps it presented until accepted.
        state_d = S_HALT;
      end else begin
`ifdef FETCH_JUMP_PREDECODE_EN
        if (imem_rdata[31:26] == 6'b000010) begin
          pc_d = imem_rdata[AW-1:0];
        end else begin
          pc_d = pc_inc;
        end
`else
        pc_d = pc_inc;
`endif
      end
    end else if (handshake) begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      if_last_q    <= 1'b0;
      issued_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      if_last_q    <= if_last_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  assign imem_addr  = pc_q;
  assign if_valid   = if_valid_q;
  assign if_instr   = if_instr_q;
  assign if_pc      = if_pc_q;
  assign if_last    = if_last_q;
  assign busy       = (state_q == S_RUN);
  assign halted     = (state_q == S_HALT) && !if_valid_q;
  assign issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
module tb_imem_fetch_sequencer;

  localparam int AW = 6;
  localparam logic [31:0] END_W = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          if_valid;
  logic          if_ready = 1'b0;
  logic [31:0]   if_instr;
  logic [AW-1:0] if_pc;
  logic          if_last;
  logic          busy;
  logic          halted;
  logic [15:0]   issued_cnt;

  logic [31:0] mem [64];
  assign imem_rdata = mem[imem_addr];

  imem_fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_last(if_last), .busy(busy), .halted(halted),
    .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The decode interface is a one-entry slot: a word sits there until taken.
  // Fetching refills the slot whenever it is (or becomes) empty while running.
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
  typedef struct packed { logic [AW-1:0] pc; logic [31:0] w; } item_t;
  item_t slot[$];
  int    mode;
  int    next_pc;
  int    n_issued;

  task automatic model_reset();
    slot.delete();
    mode = M_IDLE;
    next_pc = 0;
    n_issued = 0;
  endtask

  task automatic model_edge();
    bit took;
    logic [31:0] w;
    took = (slot.size() > 0) && if_ready;
    if (took && n_issued < 65535) n_issued++;
    if (mode != M_IDLE && redirect) begin
      slot.delete();
      next_pc = int'(redirect_pc);
      mode = M_RUN;
    end else if (mode != M_RUN && start) begin
      slot.delete();
      next_pc = int'(start_pc);
      n_issued = 0;
      mode = M_RUN;
    end else begin
      if (took) void'(slot.pop_front());
      if (mode == M_RUN && slot.size() == 0) begin
        w = mem[next_pc];
        slot.push_back('{pc: AW'(next_pc), w: w});
        if (w == END_W) mode = M_HALT;
`ifdef FETCH_JUMP_PREDECODE_EN
        else if (w[31:26] == 6'b000010) next_pc = int'(w[AW-1:0]);
`endif
        else next_pc = (next_pc + 1) % 64;
      end
    end
  endtask

  task automatic compare_all();
    chk("if_valid", 32'(if_valid), 32'(slot.size() > 0));
    chk("imem_addr", 32'(imem_addr), 32'(next_pc));
    chk("busy", 32'(busy), 32'(mode == M_RUN));
    chk("halted", 32'(halted), 32'(mode == M_HALT && slot.size() == 0));
    chk("issued_cnt", 32'(issued_cnt), 32'(n_issued));
    if (slot.size() > 0 && if_valid) begin
      chk("if_pc", 32'(if_pc), 32'(slot[0].pc));
      chk("if_instr", if_instr, slot[0].w);
      chk("if_last", 32'(if_last), 32'(slot[0].w == END_W));
    end
  endtask

  // Pcs of words decode actually accepted, observed on the DUT pins.
  logic [AW-1:0] acc[$];

  task automatic cyc();
    if (if_valid && if_ready) acc.push_back(if_pc);
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, 32'(imem_addr), 0);
    chk({tag, "_valid"}, 32'(if_valid), 0);
    chk({tag, "_instr"}, if_instr, 0);
    chk({tag, "_pc"}, 32'(if_pc), 0);
    chk({tag, "_last"}, 32'(if_last), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_halted"}, 32'(halted), 0);
    chk({tag, "_cnt"}, 32'(issued_cnt), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("rst");
    model_reset();
    start = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_nops();
    for (int i = 0; i < 64; i++) mem[i] = NOP_W;
  endtask

  task automatic go(input logic [AW-1:0] pc);
    acc.delete();
    start_pc = pc;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_until_pc(input logic [AW-1:0] pc, input int bound);
    bit found = 0;
    for (int i = 0; i < bound && !found; i++) begin
      cyc();
      if (if_valid && if_pc == pc) found = 1;
    end
    chk("wait_pc", 32'(found), 1);
  endtask

  task automatic check_acc(input string tag, input int idx, input int exp);
    if (idx < acc.size()) chk(tag, 32'(acc[idx]), 32'(exp));
    else chk({tag, "_missing"}, 32'(acc.size()), 32'(idx + 1));
  endtask

  initial begin
    model_reset();
    load_nops();
    #2 rst_n = 1'b0;
    #1 check_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // straight line program
    mem[0] = 32'h2001_0001; mem[1] = 32'h0022_1020;
    mem[2] = 32'h0022_1022; mem[3] = END_W;
    if_ready = 1'b1;
    go(0);
    repeat (7) cyc();
    chk("sl_count", 32'(acc.size()), 4);
    for (int i = 0; i < 4; i++) check_acc("sl_pc", i, i);
    chk("sl_halted", 32'(halted), 1);
    chk("sl_issued", 32'(issued_cnt), 4);

    // stall with pc 1 presented
    if_ready = 1'b0;
    go(0);
    cyc();
    if_ready = 1'b1;
    cyc();
    if_ready = 1'b0;
    repeat (3) begin
      cyc();
      chk("st_pc", 32'(if_pc), 1);
      chk("st_instr", if_instr, 32'h0022_1020);
      chk("st_addr", 32'(imem_addr), 2);
    end
    if_ready = 1'b1;
    repeat (6) cyc();
    chk("st_count", 32'(acc.size()), 4);
    for (int i = 0; i < 4; i++) check_acc("st_pc_seq", i, i);

    // redirect while pc 4 presented
    do_reset();
    load_nops();
    if_ready = 1'b1;
    go(0);
    run_until_pc(4, 20);
    redirect = 1'b1;
    redirect_pc = 10;
    cyc();
    redirect = 1'b0;
    chk("rd_bubble", 32'(if_valid), 0);
    cyc();
    chk("rd_valid", 32'(if_valid), 1);
    chk("rd_target", 32'(if_pc), 10);
    repeat (2) cyc();
    check_acc("rd_seq4", 4, 4);
    check_acc("rd_seq5", 5, 10);

    // wrong-path sentinel dropped by redirect in HALT
    do_reset();
    load_nops();
    mem[4] = 32'h1000_0005;
    mem[5] = END_W;
    if_ready = 1'b1;
    go(0);
    run_until_pc(5, 20);
    chk("wp_last", 32'(if_last), 1);
    chk("wp_busy_halt", 32'(busy), 0);
    if_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 20;
    cyc();
    redirect = 1'b0;
    chk("wp_flushed", 32'(if_valid), 0);
    chk("wp_run", 32'(busy), 1);
    cyc();
    chk("wp_target", 32'(if_pc), 20);
    chk("wp_last_clr", 32'(if_last), 0);

    // wrap 62 -> 63 -> 0, then reset mid-stream
    do_reset();
    load_nops();
    if_ready = 1'b1;
    go(62);
    repeat (5) cyc();
    check_acc("wr_0", 0, 62);
    check_acc("wr_1", 1, 63);
    check_acc("wr_2", 2, 0);
    #3 rst_n = 1'b0;
    #1 check_zero("mid_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // j 40 at address 2
    load_nops();
    mem[2] = 32'h0800_0028;
    if_ready = 1'b1;
    go(0);
    repeat (6) cyc();
    check_acc("j_at2", 2, 2);
`ifdef FETCH_JUMP_PREDECODE_EN
    check_acc("j_next", 3, 40);
`else
    check_acc("j_next", 3, 3);
`endif

    // randomized traffic against the model
    for (int blk = 0; blk < 5; blk++) begin
      do_reset();
      for (int i = 0; i < 64; i++) begin
        case ($urandom_range(11))
          0:       mem[i] = END_W;
          1:       mem[i] = {6'b000010, 20'd0, 6'($urandom_range(63))};
          default: mem[i] = $urandom;
        endcase
      end
      for (int c = 0; c < 300; c++) begin
        if_ready    = ($urandom_range(3) != 0);
        redirect    = ($urandom_range(19) == 0);
        redirect_pc = AW'($urandom_range(63));
        start       = ($urandom_range(9) == 0);
        start_pc    = AW'($urandom_range(63));
        cyc();
      end
      start = 1'b0;
      redirect = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
